nrisc_ula_seq: RTL and testbench
================================

Name: nrisc_ula_seq

Overview:
Parametrised, handshaked successor to the NRISC combinational ALU. It keeps the 4-bit control encoding, the operation set and the {minus, zero, carry} flag format. New behaviour: results and flags are registered, shifts and rotates take a multi-bit distance from B and execute iteratively one bit per cycle, and a valid/ready handshake sits on both input and output. It sits between the register-file read stage and writeback in the NRISC datapath.

Parameters:
TAM, 16, data width in bits (>= 4, power of two)
SHW, $clog2(TAM), width of the shift-distance field taken from ULA_B[SHW-1:0]

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operands and control present
in_ready  out  1  block can accept an operation
ULA_A  in  TAM  operand A
ULA_B  in  TAM  operand B; for shifts only B[SHW-1:0] is used (distance)
ULA_ctrl  in  4  [2:0] function select; [3] 0 = shift, 1 = rotate (shift ops only)
out_valid  out  1  ULA_OUT/ULA_flags valid
out_ready  in  1  consumer accepts result
ULA_OUT  out  TAM  registered result
ULA_flags  out  3  registered {minus, zero, carry}

Behaviour:
- One clock; reset is synchronous and active-high. rst sampled high at a rising edge: state=IDLE, ULA_OUT=0, ULA_flags=3'b000, out_valid=0, internal counter=0. Reset wins over every other event, including mid-shift and pending output; the in-flight operation is discarded.
- Function select [2:0]: 000 add A+B; 001 sub A-B (A + ~B + 1); 010 and; 011 or; 100 xor; 101 right shift/rotate A; 110 left shift/rotate A; 111 not A. ctrl[3] is ignored for non-shift ops.
- Flags, computed on the final result: minus = result[TAM-1]; zero = (result == 0); carry as follows:
  - add: carry-out of bit TAM-1.
  - sub: borrow, 1 iff A < B unsigned.
  - shift/rotate: last bit shifted or rotated out; 0 if distance = 0.
  - logic ops: 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE, acceptance (in_valid & in_ready at an edge): operands and ctrl are captured.
  - Non-shift op, or shift with distance 0: result and flags are written at that edge and the state goes to DONE. out_valid is high in the next cycle (latency 1).
  - Shift with distance k>0: the working register loads A, the counter loads k, and the state goes to SHIFT.
- SHIFT: each edge moves the working register one bit, decrements the counter and records the bit shifted out.
  - Shift right: fill 0 at MSB, bit 0 out.
  - Shift left: fill 0 at LSB, bit TAM-1 out.
  - Rotate: the bit out re-enters at the opposite end.
  - On the edge where the counter reaches 0, ULA_OUT and ULA_flags are written and the state goes to DONE. Total latency from acceptance to out_valid = k+1 cycles; k max = TAM-1.
- DONE: ULA_OUT, ULA_flags and out_valid are held stable until out_ready is sampled high. On that edge the state goes to IDLE and out_valid drops. No new input is accepted in the same cycle (no bypass): minimum issue interval is 2 cycles.
- Operand or ctrl changes on the inputs while not in IDLE are ignored.
- ULA_OUT and ULA_flags keep their last values in IDLE and SHIFT. Only out_valid qualifies them.
- Width rules: all arithmetic is modulo 2^TAM. Bits of B above SHW-1 are ignored for shifts.

Test Plan:
- Reset: assert rst during SHIFT with k=7 -> the next cycle shows in_ready=1, out_valid=0, ULA_OUT=0, ULA_flags=000. Release rst -> a new add completes normally.
- Add carry (TAM=16): A=0xFFFF, B=0x0001, ctrl=0000 -> out_valid one cycle after accept, ULA_OUT=0x0000, flags=011. Also A=0x7FFF, B=0x0001 -> 0x8000, flags=100.
- Sub borrow: A=0x0003, B=0x0005, ctrl=0001 -> ULA_OUT=0xFFFE, flags=101. A=B=0x1234 -> 0x0000, flags=010.
- Multi-bit shift/rotate:
  - A=0x8001, B=0x0004, ctrl=0110 (shl) -> out_valid exactly 5 cycles after accept, ULA_OUT=0x0010, carry=0.
  - Same operands, ctrl=1101 (ror) -> 0x1800, flags=000.
  - A=0x0001, B=0x0001, ctrl=0101 -> 0x0000, flags=011.
- Distance 0 and ignored high B bits: A=0xABCD, B=0x0010, ctrl=0101 -> distance 0, latency 1, ULA_OUT=0xABCD, flags=100.
- Backpressure: complete an xor A=0x00FF, B=0x0F0F (-> 0x0FF0) with out_ready=0 for 6 cycles, driving new inputs meanwhile -> ULA_OUT and flags stay 0x0FF0/000 and in_ready=0 throughout. Raise out_ready -> IDLE the next cycle, after which the next operation is accepted.

Source files
------------

// File: rtl/nrisc_ula_seq.sv
// ----------------------------------------------------------------------------
// nrisc_ula_seq
// Sequential, handshaked NRISC ALU. Results and flags {minus, zero, carry}
// are registered. Shifts and rotates move one bit per clock for a distance
// taken from ULA_B[SHW-1:0]. All other operations complete in one cycle.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operation present on ULA_A / ULA_B / ULA_ctrl
//   in_ready   block is idle and can accept an operation
//   ULA_A      operand A
//   ULA_B      operand B (shift distance in B[SHW-1:0] for shift ops)
//   ULA_ctrl   [2:0] function select, [3] 0 = shift / 1 = rotate
//   out_valid  ULA_OUT / ULA_flags hold a completed result
//   out_ready  consumer takes the result
//   ULA_OUT    registered result
//   ULA_flags  registered {minus, zero, carry}
// ----------------------------------------------------------------------------
module nrisc_ula_seq #(
    parameter int TAM = 16,
    parameter int SHW = $clog2(TAM)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    input  logic [3:0]     ULA_ctrl,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    state_t         r_state, w_state_next;
    logic [TAM-1:0] r_work,  w_work_next;
    logic [SHW-1:0] r_cnt,   w_cnt_next;
    logic           r_left,  w_left_next;   // 1 = toward MSB
    logic           r_rot,   w_rot_next;    // 1 = rotate, 0 = zero fill
    logic [TAM-1:0] r_out,   w_out_next;
    logic [2:0]     r_flags, w_flags_next;

    logic [2:0]     w_sel;
    logic [SHW-1:0] w_dist;
    logic           w_is_shift;
    logic [TAM:0]   w_add;
    logic [TAM:0]   w_sub;
    logic [TAM-1:0] w_imm_res;
    logic           w_imm_carry;
    logic [TAM-1:0] w_step_res;
    logic           w_step_out;

    assign w_sel      = ULA_ctrl[2:0];
    assign w_dist     = ULA_B[SHW-1:0];
    assign w_is_shift = (w_sel == OP_SHR) || (w_sel == OP_SHL);

    // Extra top bit carries the carry-out for add and the borrow for sub.
    assign w_add = {1'b0, ULA_A} + {1'b0, ULA_B};
    assign w_sub = {1'b0, ULA_A} - {1'b0, ULA_B};

    // Single-cycle result. A shift reaching this path has distance 0,
    // so it passes A through with carry 0.
    always_comb begin
        w_imm_res   = '0;
        w_imm_carry = 1'b0;
        case (w_sel)
            OP_ADD: begin
                w_imm_res   = w_add[TAM-1:0];
                w_imm_carry = w_add[TAM];
            end
            OP_SUB: begin
                w_imm_res   = w_sub[TAM-1:0];
                w_imm_carry = w_sub[TAM];
            end
            OP_AND:  w_imm_res = ULA_A & ULA_B;
            OP_OR:   w_imm_res = ULA_A | ULA_B;
            OP_XOR:  w_imm_res = ULA_A ^ ULA_B;
            OP_NOT:  w_imm_res = ~ULA_A;
            default: w_imm_res = ULA_A;
        endcase
    end

    // One-bit step of the working register; the outgoing bit re-enters
    // at the opposite end only when rotating.
    always_comb begin
        if (r_left) begin
            w_step_out = r_work[TAM-1];
            w_step_res = {r_work[TAM-2:0], r_rot & r_work[TAM-1]};
        end else begin
            w_step_out = r_work[0];
            w_step_res = {r_rot & r_work[0], r_work[TAM-1:1]};
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_work_next  = r_work;
        w_cnt_next   = r_cnt;
        w_left_next  = r_left;
        w_rot_next   = r_rot;
        w_out_next   = r_out;
        w_flags_next = r_flags;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_is_shift && (w_dist != '0)) begin
                        w_work_next  = ULA_A;
                        w_cnt_next   = w_dist;
                        w_left_next  = (w_sel == OP_SHL);
                        w_rot_next   = ULA_ctrl[3];
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_out_next   = w_imm_res;
                        w_flags_next = {w_imm_res[TAM-1], (w_imm_res == '0), w_imm_carry};
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                w_work_next = w_step_res;
                w_cnt_next  = r_cnt - 1'b1;
                // Counter reaches zero on this edge: publish the result.
                if (r_cnt == SHW'(1)) begin
                    w_out_next   = w_step_res;
                    w_flags_next = {w_step_res[TAM-1], (w_step_res == '0), w_step_out};
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_rot   <= 1'b0;
            r_out   <= '0;
            r_flags <= 3'b000;
        end else begin
            r_state <= w_state_next;
            r_work  <= w_work_next;
            r_cnt   <= w_cnt_next;
            r_left  <= w_left_next;
            r_rot   <= w_rot_next;
            r_out   <= w_out_next;
            r_flags <= w_flags_next;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign ULA_OUT   = r_out;
    assign ULA_flags = r_flags;

endmodule

// File: tb/tb_nrisc_ula_seq.sv
// ----------------------------------------------------------------------------
// tb_nrisc_ula_seq
// Directed vectors for nrisc_ula_seq (TAM = 16). The stimulus process pushes
// the expected result, flags and latency into a queue at issue time; a
// separate monitor pops on each new out_valid, checks it, and keeps checking
// that the output is held stable while the consumer applies backpressure.
// ----------------------------------------------------------------------------
module tb_nrisc_ula_seq;

    localparam int TAM = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [TAM-1:0] ULA_A;
    logic [TAM-1:0] ULA_B;
    logic [3:0]     ULA_ctrl;
    logic           out_valid;
    logic           out_ready;
    logic [TAM-1:0] ULA_OUT;
    logic [2:0]     ULA_flags;

    nrisc_ula_seq #(.TAM(TAM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ULA_A     (ULA_A),
        .ULA_B     (ULA_B),
        .ULA_ctrl  (ULA_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ULA_OUT   (ULA_OUT),
        .ULA_flags (ULA_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAM-1:0] res;
        logic [2:0]     flags;
        int             lat;
        int             acc;
        int             id;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_id  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        bit             prev_valid;
        exp_t           cur;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !out_valid) begin
                prev_valid = 1'b0;
            end else begin
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got %h/%b, required no output", ULA_OUT, ULA_flags);
                    end else begin
                        cur = q.pop_front();
                        $display("txn %0d: out=%h flags=%b latency=%0d", cur.id, ULA_OUT, ULA_flags, cyc - cur.acc + 1);
                        chk($sformatf("result[%0d]", cur.id), 32'(ULA_OUT), 32'(cur.res));
                        chk($sformatf("flags[%0d]", cur.id), 32'(ULA_flags), 32'(cur.flags));
                        chk($sformatf("latency[%0d]", cur.id), 32'(cyc - cur.acc + 1), 32'(cur.lat));
                    end
                end else begin
                    chk($sformatf("hold_result[%0d]", cur.id), 32'(ULA_OUT), 32'(cur.res));
                    chk($sformatf("hold_flags[%0d]", cur.id), 32'(ULA_flags), 32'(cur.flags));
                end
                chk("in_ready_while_valid", 32'(in_ready), 32'd0);
                prev_valid = !out_ready;
            end
        end
    end

    // Called at posedge+1; waits for IDLE, presents one operation for one edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c,
                         input logic [15:0] res, input logic [2:0] fl, input int lat);
        exp_t e;
        int   n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("issue_wait_in_ready", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        ULA_A    = a;
        ULA_B    = b;
        ULA_ctrl = c;
        e.res    = res;
        e.flags  = fl;
        e.lat    = lat;
        e.acc    = cyc + 1;
        e.id     = n_id;
        n_id++;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for the output handshake to complete.
    task automatic wait_done();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (out_valid && out_ready) found = 1'b1;
            @(posedge clk); #1;
        end
        if (!found) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: got no output handshake within 40 cycles, required one");
            q.delete();
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c,
                       input logic [15:0] res, input logic [2:0] fl, input int lat);
        issue(a, b, c, res, fl, lat);
        wait_done();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ULA_A     = '0;
        ULA_B     = '0;
        ULA_ctrl  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", 32'(ULA_OUT), 32'd0);
        chk("reset_flags", 32'(ULA_flags), 32'd0);
        rst = 1'b0;

        //   A         B         ctrl     result    flags   latency
        run(16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 3'b011, 1);   // add carry-out
        run(16'h7FFF, 16'h0001, 4'b0000, 16'h8000, 3'b100, 1);   // add to negative
        run(16'h0001, 16'h0002, 4'b1000, 16'h0003, 3'b000, 1);   // ctrl[3] ignored
        run(16'h0003, 16'h0005, 4'b0001, 16'hFFFE, 3'b101, 1);   // sub borrow
        run(16'h1234, 16'h1234, 4'b0001, 16'h0000, 3'b010, 1);   // sub equal
        run(16'h0005, 16'h0003, 4'b1001, 16'h0002, 3'b000, 1);   // sub no borrow
        run(16'hF0F0, 16'h0FF0, 4'b0010, 16'h00F0, 3'b000, 1);   // and
        run(16'hF000, 16'h000F, 4'b0011, 16'hF00F, 3'b100, 1);   // or
        run(16'h00FF, 16'h1234, 4'b0111, 16'hFF00, 3'b100, 1);   // not A
        run(16'h8001, 16'h0004, 4'b0110, 16'h0010, 3'b000, 5);   // shl 4
        run(16'h8001, 16'h0004, 4'b1101, 16'h1800, 3'b000, 5);   // ror 4
        run(16'h0001, 16'h0001, 4'b0101, 16'h0000, 3'b011, 2);   // shr 1
        run(16'h8001, 16'h0001, 4'b1110, 16'h0003, 3'b001, 2);   // rol 1
        run(16'hABCD, 16'h0010, 4'b0101, 16'hABCD, 3'b100, 1);   // distance 0
        run(16'h0003, 16'h000F, 4'b0110, 16'h8000, 3'b101, 16);  // shl max
        run(16'h0001, 16'hFFFF, 4'b1101, 16'h0002, 3'b000, 16);  // ror max

        // Backpressure: result held, inputs ignored, no acceptance.
        out_ready = 1'b0;
        issue(16'h00FF, 16'h0F0F, 4'b0100, 16'h0FF0, 3'b000, 1);
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            ULA_A    = 16'(i * 16'h1111);
            ULA_B    = 16'h0003;
            ULA_ctrl = 4'b0000;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_done();
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(out_valid), 32'd0);
        run(16'h0001, 16'h0001, 4'b0000, 16'h0002, 3'b000, 1);

        // Reset in the middle of a 7-bit shift.
        issue(16'h0003, 16'h0007, 4'b0110, 16'h0180, 3'b000, 8);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(ULA_OUT), 32'd0);
        chk("midrst_flags", 32'(ULA_flags), 32'd0);
        rst = 1'b0;
        run(16'h0002, 16'h0003, 4'b0000, 16'h0005, 3'b000, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
